// File: rtl/cond_logic_pkg.sv
// Shared constants for the conditional-execution stage: ARM condition codes and NZCV bit positions.
package cond_logic_pkg;

  localparam int unsigned COND_W  = 4;
  localparam int unsigned FLAGS_W = 4;

  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;
  localparam logic [COND_W-1:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_logic_if.sv
// Control-unit side bundle of the conditional-execution stage: FSM requests in, gated enables and flags out.
interface cond_logic_if;
  import cond_logic_pkg::*;

  logic [COND_W-1:0]  Cond;
  logic [FLAGS_W-1:0] ALUFlags;
  logic [1:0]         FlagW;
  logic               NextPC;
  logic               Branch;
  logic               RegW;
  logic               MemW;
  logic               PCWrite;
  logic               RegWrite;
  logic               MemWrite;
  logic [FLAGS_W-1:0] Flags;

  // Driven by the control FSM / decoder side
  modport master (
    output Cond, ALUFlags, FlagW, NextPC, Branch, RegW, MemW,
    input  PCWrite, RegWrite, MemWrite, Flags
  );

  // Implemented by cond_logic
  modport slave (
    input  Cond, ALUFlags, FlagW, NextPC, Branch, RegW, MemW,
    output PCWrite, RegWrite, MemWrite, Flags
  );
endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator. Define COND_NV_NEVER_EN to make Cond=1111 never execute.
module cond_check
  import cond_logic_pkg::*;
(
  input  logic [COND_W-1:0]  Cond,
  input  logic [FLAGS_W-1:0] Flags,
  output logic               CondEx
);

  logic n, z, c, v, ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = !z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = !c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = !n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = !v;
      COND_HI: CondEx = c && !z;
      COND_LS: CondEx = !c || z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = !ge;
      COND_GT: CondEx = !z && ge;
      COND_LE: CondEx = z || !ge;
      COND_AL: CondEx = 1'b1;
`ifdef COND_NV_NEVER_EN
      COND_NV: CondEx = 1'b0;
`else
      COND_NV: CondEx = 1'b1;
`endif
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV flag register, condition evaluation and gating of FSM write requests.
// Build option: COND_NV_NEVER_EN (Cond=1111 treated as never, see cond_check).
module cond_logic
  import cond_logic_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  cond_logic_if.slave  bus
);

  logic               cond_ex;
  logic               cond_ex_q;
  logic [1:0]         flag_write;
  logic [FLAGS_W-1:0] flags_q;

  cond_check u_cond_check (
    .Cond   (bus.Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  // Flags are written in execute, so use the undelayed condition result
  assign flag_write = bus.FlagW & {2{cond_ex}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q   <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      cond_ex_q <= cond_ex;
      if (flag_write[1]) flags_q[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
      if (flag_write[0]) flags_q[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
    end
  end

  // Writeback decisions use the condition captured on the previous cycle; fetch is never gated
  assign bus.RegWrite = bus.RegW & cond_ex_q;
  assign bus.MemWrite = bus.MemW & cond_ex_q;
  assign bus.PCWrite  = (bus.Branch & cond_ex_q) | bus.NextPC;
  assign bus.Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic with hand-computed expectations.
module tb_cond_logic;
  import cond_logic_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  cond_logic_if bus ();

  cond_logic dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_flags(input logic [3:0] f);
    bus.Cond     = COND_AL;
    bus.FlagW    = 2'b11;
    bus.ALUFlags = f;
    tick();
    bus.FlagW    = 2'b00;
  endtask

  initial begin
    logic exp_nv;
    total = 0;
    bad   = 0;
    bus.Cond = COND_AL; bus.ALUFlags = 4'b0000; bus.FlagW = 2'b00;
    bus.NextPC = 1'b0; bus.Branch = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0;
    reset = 1'b0;

    // reset and first AL instruction
    tick();
    check("reset_flags", bus.Flags, 4'b0000);
    check("reset_pcw", {3'b0, bus.PCWrite}, 4'd0);
    bus.NextPC = 1'b1;
    #1 check("reset_pcw_nextpc", {3'b0, bus.PCWrite}, 4'd1);
    bus.NextPC = 1'b0;
    reset = 1'b1; bus.Cond = COND_AL; bus.RegW = 1'b1;
    #1 check("release_regw0", {3'b0, bus.RegWrite}, 4'd0);
    tick();
    check("al_regw1", {3'b0, bus.RegWrite}, 4'd1);
    check("al_flags", bus.Flags, 4'b0000);
    bus.RegW = 1'b0;

    // partial flag writes
    bus.ALUFlags = 4'b1111; bus.FlagW = 2'b10;
    tick();
    check("flagw10", bus.Flags, 4'b1100);
    bus.FlagW = 2'b01;
    tick();
    check("flagw01", bus.Flags, 4'b1111);
    bus.FlagW = 2'b00;

    // branch not taken on EQ with Z=0
    set_flags(4'b0000);
    check("clear_flags", bus.Flags, 4'b0000);
    bus.Cond = COND_EQ; bus.Branch = 1'b1;
    tick();
    check("beq_not_taken", {3'b0, bus.PCWrite}, 4'd0);
    bus.NextPC = 1'b1;
    #1 check("nextpc_ungated", {3'b0, bus.PCWrite}, 4'd1);
    bus.NextPC = 1'b0; bus.Cond = COND_NE;
    tick();
    check("bne_taken", {3'b0, bus.PCWrite}, 4'd1);
    bus.Branch = 1'b0;

    // store suppression: N=1,V=0
    set_flags(4'b1000);
    check("flags_n", bus.Flags, 4'b1000);
    bus.Cond = COND_GE; bus.MemW = 1'b1;
    tick();
    check("ge_store_off", {3'b0, bus.MemWrite}, 4'd0);
    bus.Cond = COND_LT;
    #1 check("lt_store_lag", {3'b0, bus.MemWrite}, 4'd0);
    tick();
    check("lt_store_on", {3'b0, bus.MemWrite}, 4'd1);
    bus.MemW = 1'b0;

    // same-cycle evaluate/update: EQ false blocks the flag write
    set_flags(4'b0000);
    bus.Cond = COND_EQ; bus.FlagW = 2'b11; bus.ALUFlags = 4'b0100; bus.RegW = 1'b1;
    tick();
    check("eq_flagw_blocked", bus.Flags, 4'b0000);
    check("eq_regw_off", {3'b0, bus.RegWrite}, 4'd0);
    // NE true on pre-update flags, so the write goes through
    bus.Cond = COND_NE;
    tick();
    check("ne_flagw_taken", bus.Flags, 4'b0100);
    bus.FlagW = 2'b00; bus.Cond = COND_EQ;
    tick();
    check("eq_after_update", {3'b0, bus.RegWrite}, 4'd1);

    // HI / LS with C=1,Z=0; GT / LE with Z=0,N=V
    set_flags(4'b0010);
    bus.RegW = 1'b1; bus.Cond = COND_HI;
    tick();
    check("hi_true", {3'b0, bus.RegWrite}, 4'd1);
    bus.Cond = COND_LS;
    tick();
    check("ls_false", {3'b0, bus.RegWrite}, 4'd0);
    bus.Cond = COND_GT;
    tick();
    check("gt_true", {3'b0, bus.RegWrite}, 4'd1);
    bus.Cond = COND_LE;
    tick();
    check("le_false", {3'b0, bus.RegWrite}, 4'd0);

    // NV encoding
`ifdef COND_NV_NEVER_EN
    exp_nv = 1'b0;
`else
    exp_nv = 1'b1;
`endif
    bus.Cond = COND_NV;
    tick();
    check("nv_regw", {3'b0, bus.RegWrite}, {3'b0, exp_nv});

    // reset mid-instruction suppresses pending writes
    set_flags(4'b1011);
    check("flags_pre_reset", bus.Flags, 4'b1011);
    bus.Cond = COND_AL; bus.RegW = 1'b1; bus.MemW = 1'b1;
    tick();
    check("pre_reset_regw", {3'b0, bus.RegWrite}, 4'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("midreset_flags", bus.Flags, 4'b0000);
    check("midreset_regw", {3'b0, bus.RegWrite}, 4'd0);
    check("midreset_memw", {3'b0, bus.MemWrite}, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
# cond_logic

Conditional-execution stage of the multi-cycle ARM control unit. It sits directly downstream of the main control FSM. It holds the NZCV flag register and evaluates the instruction's 4-bit condition field against those flags. It then gates the FSM's raw write requests (RegW, MemW, Branch, NextPC) into the architectural write enables that drive the register file, data memory and PC.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk, effective when 0.
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  ALU result flags {N,Z,C,V}.
- FlagW  in  2  from ALU decoder; bit1 = update N,Z; bit0 = update C,V.
- NextPC  in  1  FSM: unconditional PC write (fetch).
- Branch  in  1  FSM: conditional PC write (branch writeback).
- RegW  in  1  FSM: register-file write request.
- MemW  in  1  FSM: memory write request.
- PCWrite  out  1  PC register enable.
- RegWrite  out  1  register-file write enable.
- MemWrite  out  1  data-memory write enable.
- Flags  out  4  current registered {N,Z,C,V}; the datapath uses C as carry-in.

## Operation
- CondEx is a combinational function of Cond and the registered Flags, with Flags = {N,Z,C,V}:
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C.
  - MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z.
  - GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 1; 1111 see Configuration.
- CondExQ is a 1-bit register. It loads CondEx on every clock edge.
- FlagWrite[1:0] = FlagW & {CondEx, CondEx}. It uses the undelayed CondEx because flags are written in the execute stage.
- Flags[3:2] load ALUFlags[3:2] when FlagWrite[1] is set. Flags[1:0] load ALUFlags[1:0] when FlagWrite[0] is set. Otherwise the flags hold.
- RegWrite = RegW & CondExQ.
- MemWrite = MemW & CondExQ.
- PCWrite = (Branch & CondExQ) | NextPC.
- NextPC is never gated.

## Timing
- Reset (reset=0 at an edge) sets Flags = 4'b0000 and CondExQ = 0.
  - While CondExQ = 0: RegWrite = 0, MemWrite = 0, PCWrite = NextPC.
  - After reset, EQ evaluates false and NE/AL evaluate true.
- Reset asserted mid-instruction clears both registers on that edge. A pending RegW or MemW the next cycle is suppressed.
- Latency:
  - Flags update 1 cycle after the FlagW/ALUFlags sample.
  - Gated outputs are combinational from the inputs and CondExQ, with 0-cycle latency.
  - Decisions reflect the CondEx value from the previous cycle.
- Simultaneous flag write and condition evaluation in the same cycle: CondEx uses the pre-update Flags. The new flags are visible from the next cycle.
- A partial FlagW (01 or 10) leaves the other flag pair unchanged.
- Cond must be held stable from decode through writeback. The block relies on the instruction register holding it there and does not latch Cond itself.

## Configuration
- COND_NV_NEVER_EN defined: Cond=1111 evaluates CondEx = 0, so the instruction is a no-op. This is the pre-v5 NV semantics.
- COND_NV_NEVER_EN undefined (default): Cond=1111 evaluates CondEx = 1 (unconditional).

## Structure
- The shared package holds:
  - condition-code constants COND_EQ … COND_AL, COND_NV;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module, cond_check (Cond, Flags → CondEx), instantiated once.
- The flag and CondExQ registers stay in cond_logic.

## Test plan
- Reset then AL: reset=0 for one edge, then Cond=1110, RegW=1 → the first cycle after release has RegWrite=0 (CondExQ=0). The following cycle has RegWrite=1. Flags=0000.
- Flag write with partial enable: Flags=0000, ALUFlags=1111, FlagW=10, Cond=AL → next cycle Flags=1100. Then FlagW=01 → Flags=1111.
- Branch not taken: Flags Z=0, Cond=EQ, Branch=1, NextPC=0 → after one cycle PCWrite=0. With NextPC=1 → PCWrite=1.
- Store suppression: Flags N=1, V=0, Cond=GE, MemW=1 → MemWrite=0. With Cond=LT → MemWrite=1 one cycle later.
- Same-cycle update/evaluate: Flags Z=0, Cond=EQ, FlagW=11, ALUFlags=0100 → FlagWrite=00 (CondEx=0), so Flags remain 0000.
- Cond=1111, RegW=1: with COND_NV_NEVER_EN defined → RegWrite=0. Undefined → RegWrite=1.
